// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Wait-state data-memory responder for the multicycle core's data
//            port. Accepts one word load/store, waits LATENCY cycles, commits
//            on the edge entering DONE and pulses Ready (with Err if illegal).
//            Owns a DEPTH x 32 word RAM that is never reset.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        We,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Err,
  output logic        Busy
);

  // Word-index width; at least one bit so a single-word RAM still indexes.
  localparam int c_ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Down-counter width; at least one bit even when there are no wait cycles.
  localparam int c_CNT_W  = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  localparam logic [c_CNT_W-1:0] c_CNT_LOAD  = c_CNT_W'((LATENCY > 0) ? (LATENCY - 1) : 0);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [29:0]        c_DEPTH_W   = 30'(DEPTH);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_WAIT = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_next;
  logic [c_CNT_W-1:0]  r_cnt;

  // Captured request
  logic                r_we;
  logic                r_ill;
  logic [c_ADDR_W-1:0] r_idx;
  logic [31:0]         r_wdata;

  logic [31:0]         r_rdata;
  logic [31:0]         r_mem [0:DEPTH-1];

  logic                w_accept;
  logic                w_in_ill;
  logic [c_ADDR_W-1:0] w_in_idx;
  logic                w_commit;
  logic                w_from_idle;
  logic                w_c_we;
  logic                w_c_ill;
  logic [c_ADDR_W-1:0] w_c_idx;
  logic [31:0]         w_c_wdata;

  assign w_accept = (r_state == c_IDLE) && Req;
  assign w_in_ill = (Adr[1:0] != 2'b00) || (Adr[31:2] >= c_DEPTH_W);
  assign w_in_idx = Adr[c_ADDR_W+1:2];

  // Commit happens on the edge that enters DONE. With zero latency that edge
  // is the accept edge itself, so the commit source must bypass the capture
  // registers and use the live request inputs.
  assign w_commit    = reset && (w_next == c_DONE);
  assign w_from_idle = (r_state == c_IDLE);
  assign w_c_we      = w_from_idle ? We        : r_we;
  assign w_c_ill     = w_from_idle ? w_in_ill  : r_ill;
  assign w_c_idx     = w_from_idle ? w_in_idx  : r_idx;
  assign w_c_wdata   = w_from_idle ? WriteData : r_wdata;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (Req) begin
          if (LATENCY > 0) begin
            w_next = c_WAIT;
          end else begin
            w_next = c_DONE;
          end
        end
      end
      c_WAIT: begin
        if (r_cnt == '0) begin
          w_next = c_DONE;
        end
      end
      c_DONE:  w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  // Status outputs decoded from registered state only
  always_comb begin
    Ready = (r_state == c_DONE);
    Err   = (r_state == c_DONE) && r_ill;
    Busy  = (r_state == c_WAIT) || (r_state == c_DONE);
  end

  // Wait-cycle down-counter, loaded at accept
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= c_CNT_LOAD;
    end else if ((r_state == c_WAIT) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - c_CNT_ONE;
    end
  end

  // Request capture at accept
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_ill   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_we    <= We;
      r_ill   <= w_in_ill;
      r_idx   <= w_in_idx;
      r_wdata <= WriteData;
    end
  end

  // RAM write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (w_commit && w_c_we && !w_c_ill) begin
      r_mem[w_c_idx] <= w_c_wdata;
    end
  end

  // Load result register; cleared by illegal accesses, untouched by stores
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rdata <= '0;
    end else if (w_commit) begin
      if (w_c_ill) begin
        r_rdata <= '0;
      end else if (!w_c_we) begin
        r_rdata <= r_mem[w_c_idx];
      end
    end
  end

  assign ReadData = r_rdata;

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Wait-state data-memory responder serving load/store requests from the multicycle ARM core's data port. Each request is a single-word access captured on a request handshake, held for a parameterized number of wait cycles, then committed and acknowledged with a one-cycle `Ready` pulse. Misaligned and out-of-range accesses are flagged with `Err`. The block sits between the core's memory-request logic and a word-addressed RAM array that the block owns internally.

## Interface
- `DEPTH`, 64: number of 32-bit words; valid word index 0..DEPTH-1.
- `LATENCY`, 2: wait cycles between accept and completion; legal range 0..15.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low; 0 at a rising edge resets the block.
- `Req`  in  1  request valid; sampled only in IDLE.
- `We`  in  1  1 = store, 0 = load; captured at accept.
- `Adr`  in  32  byte address; captured at accept.
- `WriteData`  in  32  store data; captured at accept.
- `ReadData`  out  32  load result; registered and held until the next completion.
- `Ready`  out  1  one-cycle completion pulse.
- `Err`  out  1  asserted together with `Ready` when the access was illegal.
- `Busy`  out  1  high from the cycle after accept through the `Ready` cycle.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE: if `Req`=1 at an edge, latch `We`, `Adr`, `WriteData` and the legality check. The access is illegal if `Adr[1:0]`≠0 or `Adr[31:2]`≥DEPTH.
  - If LATENCY>0: load the down-counter with LATENCY-1 and go to WAIT.
  - If LATENCY=0: go to DONE.
- If `Req`=0 in IDLE, stay in IDLE.
- WAIT: decrement the counter each cycle; when the counter is 0, go to DONE. Inputs are ignored.
- Commit occurs on the edge entering DONE:
  - Legal store: `RAM[Adr[31:2]]` ← latched `WriteData`; `ReadData` is unchanged.
  - Legal load: `ReadData` ← `RAM[Adr[31:2]]`.
  - Illegal access: no RAM write; `ReadData` ← 0.
- DONE: `Ready`=1 for exactly one cycle; `Err`=1 if the access was illegal. Unconditionally go to IDLE. `Req` is ignored in DONE.
- A requester that holds `Req` high through DONE has a new request accepted in the following IDLE cycle. This is intended back-to-back behaviour.
- Counter width is $clog2(LATENCY+1), minimum 1 bit.
- Reset (`reset`=0 at an edge):
  - State goes to IDLE; `Ready`, `Err`, `Busy` go to 0; `ReadData` goes to 0; the counter is cleared.
  - An in-flight access is aborted and never commits.
  - RAM contents are not reset.

## Timing
- Request sampled in cycle 0 (IDLE, `Req`=1) means `Ready`=1 in cycle LATENCY+1, and `Busy`=1 in cycles 1..LATENCY+1.
- Minimum request spacing is LATENCY+2 cycles: accept, LATENCY wait cycles, DONE, then the next IDLE accept.
- `ReadData` and `Err` are valid in the `Ready` cycle. `ReadData` holds its value until the next completion or reset; `Err` is 0 outside `Ready` cycles.
- Load after store: a load accepted after a store's DONE returns the stored value.
- All outputs are registered or decoded from registered state only; there are no combinational paths from inputs to outputs.
- `Ready`, `Err`, `Busy` are 0 in the first cycle after reset is released, even if `Req`=1 during reset.

## Test plan
- LATENCY=2: store 0x0000_0007 to Adr 100 (cycle 0), then load from Adr 100 → `Ready` in cycle 3 and again 4 cycles later with `ReadData`=0x0000_0007, `Err`=0, `Busy` high exactly 3 cycles per access.
- LATENCY=0: load from Adr 0 after storing 0xDEAD_BEEF → `Ready` in the cycle right after accept, `ReadData`=0xDEAD_BEEF, `Busy` one cycle.
- Misaligned store to Adr 0x62 with data 0x55 → `Ready`=`Err`=1 in cycle 3, `ReadData`=0; a following load from 0x60 returns its prior contents unchanged.
- Out-of-range load from Adr 256 (DEPTH=64) → `Err`=1, `ReadData`=0; then a legal load → `Err`=0.
- `Req` held high continuously with alternating addresses 0/4 → accepts every 4 cycles (LATENCY=2); `Ready` pulses are single-cycle and never adjacent.
- Store to Adr 8 accepted, `reset`=0 in cycle 1 → no `Ready`; all outputs 0 next cycle; a later load from 8 returns the pre-store value.
